// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: PC register, icache miss/redirect FSM and IF/ID pipeline register.
// Define IFETCH_MISALIGN_TRAP_EN to redirect misaligned branch targets to TRAP_VECTOR.
//   state         | meaning
//   FETCH         | icache hit path, PC advances each unstalled cycle
//   MISS          | icache miss outstanding, PC held
//   MISS_REDIRECT | miss outstanding with a branch target parked in pend_q
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        icache_busywait,
  input  logic [31:0] icache_instruction,
  output logic [31:0] icache_address,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        misaligned_trap
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, MISS, MISS_REDIRECT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        trap_q, trap_d;

  logic [31:0] pc_plus4;
  logic [31:0] tgt_sel;
  logic        tgt_misaligned;
  logic [31:0] tgt_addr;

  assign pc_plus4 = pc_q + 32'd4;

  // A branch arriving on the same edge a parked redirect resolves is the newer one and wins.
  assign tgt_sel        = (state_q == MISS_REDIRECT && !branch_taken) ? pend_q : branch_target;
  assign tgt_misaligned = TRAP_EN && (tgt_sel[1:0] != 2'b00);
  assign tgt_addr       = tgt_misaligned ? TRAP_VECTOR : {tgt_sel[31:2], 2'b00};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    trap_d  = 1'b0;
    case (state_q)
      FETCH, MISS: begin
        if (branch_taken) begin
          valid_d = 1'b0;
          if (icache_busywait) begin
            pend_d  = branch_target;
            state_d = MISS_REDIRECT;
          end else begin
            pc_d    = tgt_addr;
            trap_d  = tgt_misaligned;
            state_d = FETCH;
          end
        end else if (icache_busywait) begin
          state_d = MISS;
          if (!stall) valid_d = 1'b0;
        end else begin
          state_d = FETCH;
          if (!stall) begin
            ifpc_d  = pc_q;
            ifpc4_d = pc_plus4;
            instr_d = icache_instruction;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end
      end
      MISS_REDIRECT: begin
        if (branch_taken) pend_d = branch_target;
        if (branch_taken || !stall) valid_d = 1'b0;
        // Data returned for the abandoned address is dropped here.
        if (!icache_busywait) begin
          pc_d    = tgt_addr;
          trap_d  = tgt_misaligned;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    if (flush) valid_d = 1'b0;
    if (!valid_d) instr_d = NOP;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      ifpc_q  <= 32'h0;
      ifpc4_q <= 32'h0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ifpc_q  <= ifpc_d;
      ifpc4_q <= ifpc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
    end
  end

  assign icache_address  = pc_q;
  assign if_pc           = ifpc_q;
  assign if_pc_plus4     = ifpc4_q;
  assign if_instruction  = instr_q;
  assign if_valid        = valid_q;
  assign misaligned_trap = trap_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed vector table, hand sequences, random run vs reference model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TV  = 32'h0000_0100;
`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken, icache_busywait;
  logic [31:0] branch_target, icache_instruction;
  logic [31:0] icache_address, if_pc, if_pc_plus4, if_instruction;
  logic        if_valid, misaligned_trap;
  logic [31:0] icache_address2, if_pc2, if_pc_plus42, if_instruction2;
  logic        if_valid2, misaligned_trap2;

  int errors = 0;
  int checks = 0;

  instruction_fetch_stage dut (
    .clock(clock), .reset(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .icache_busywait(icache_busywait), .icache_instruction(icache_instruction),
    .icache_address(icache_address), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .if_instruction(if_instruction), .if_valid(if_valid), .misaligned_trap(misaligned_trap)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clock(clock), .reset(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .icache_busywait(icache_busywait), .icache_instruction(icache_instruction),
    .icache_address(icache_address2), .if_pc(if_pc2), .if_pc_plus4(if_pc_plus42),
    .if_instruction(if_instruction2), .if_valid(if_valid2), .misaligned_trap(misaligned_trap2)
  );

  always #5 clock = ~clock;

  // Reference model: what the pipeline register and PC should hold after each edge.
  logic [31:0] m_pc, m_pend, m_ifpc, m_ifpc4, m_instr;
  bit          m_pend_v, m_v, m_trap;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_pend_v = 1'b0; m_v = 1'b0;
    m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_instr = NOP; m_trap = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t);
    if (TRAP_EN && t[1:0] != 2'b00) begin
      m_pc = TV; m_trap = 1'b1;
    end else begin
      m_pc = t & 32'hFFFF_FFFC;
    end
  endtask

  task automatic model_update();
    m_trap = 1'b0;
    if (m_pend_v) begin
      if (branch_taken) m_pend = branch_target;
      if (branch_taken || !stall) m_v = 1'b0;
      if (!icache_busywait) begin
        redirect(m_pend); m_pend_v = 1'b0; m_v = 1'b0;
      end
    end else if (branch_taken) begin
      m_v = 1'b0;
      if (icache_busywait) begin
        m_pend_v = 1'b1; m_pend = branch_target;
      end else redirect(branch_target);
    end else if (icache_busywait) begin
      if (!stall) m_v = 1'b0;
    end else if (!stall) begin
      m_ifpc = m_pc; m_ifpc4 = m_pc + 32'd4; m_instr = mem(m_pc); m_v = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    if (flush) m_v = 1'b0;
  endtask

  // Called at a negedge: drive inputs for the coming posedge and return at the next negedge.
  task automatic step(input bit s, input bit f, input bit b, input logic [31:0] t, input bit bz);
    stall = s; flush = f; branch_taken = b; branch_target = t; icache_busywait = bz;
    icache_instruction = mem(m_pc);
    model_update();
    @(negedge clock);
  endtask

  task automatic chk_model();
    chk("rnd_addr", icache_address, m_pc);
    chk("rnd_valid", {31'h0, if_valid}, {31'h0, m_v});
    chk("rnd_instr", if_instruction, m_v ? m_instr : NOP);
    chk("rnd_trap", {31'h0, misaligned_trap}, {31'h0, m_trap});
    if (m_v) begin
      chk("rnd_pc", if_pc, m_ifpc);
      chk("rnd_pc4", if_pc_plus4, m_ifpc4);
    end
  endtask

  typedef struct {
    bit          s, f, b;
    logic [31:0] t;
    bit          bz;
    logic [31:0] addr;
    bit          v;
    logic [31:0] pc;
    bit          trap;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit s, input bit f, input bit b, input logic [31:0] t, input bit bz,
                     input logic [31:0] addr, input bit v, input logic [31:0] pc, input bit trap);
    vec_t r;
    r.s = s; r.f = f; r.b = b; r.t = t; r.bz = bz;
    r.addr = addr; r.v = v; r.pc = pc; r.trap = trap;
    tbl.push_back(r);
  endtask

  initial begin
    logic [31:0] exp_a;
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h04,1'b1,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h08,1'b1,32'h04,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h0C,1'b1,32'h08,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h10,1'b1,32'h0C,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b1, 32'h10,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b1, 32'h10,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b1, 32'h10,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h14,1'b1,32'h10,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h18,1'b1,32'h14,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h1C,1'b1,32'h18,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h20,1'b1,32'h1C,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b1, 32'h20,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b1,32'h40,1'b1, 32'h20,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b1, 32'h20,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h40,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h44,1'b1,32'h40,1'b0);
    add(1'b1,1'b0,1'b0,32'h0 ,1'b0, 32'h44,1'b1,32'h40,1'b0);
    add(1'b1,1'b0,1'b1,32'h80,1'b0, 32'h80,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, 32'h84,1'b1,32'h80,1'b0);
    add(1'b0,1'b1,1'b0,32'h0 ,1'b0, 32'h88,1'b0,32'h00,1'b0);
    add(1'b0,1'b0,1'b1,32'h42,1'b0, TRAP_EN ? 32'h100 : 32'h40,1'b0,32'h00,TRAP_EN);
    add(1'b0,1'b0,1'b0,32'h0 ,1'b0, TRAP_EN ? 32'h104 : 32'h44,1'b1,
        TRAP_EN ? 32'h100 : 32'h40,1'b0);

    stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    icache_busywait = 1'b0; icache_instruction = 32'h0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_addr", icache_address, 32'h0);
    chk("rst_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc_plus4, 32'h0);
    chk("rst_instr", if_instruction, NOP);
    chk("rst_trap", {31'h0, misaligned_trap}, 32'h0);
    chk("rst_addr2", icache_address2, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].t, tbl[i].bz);
      chk($sformatf("vec%0d_addr", i), icache_address, tbl[i].addr);
      chk($sformatf("vec%0d_valid", i), {31'h0, if_valid}, {31'h0, tbl[i].v});
      chk($sformatf("vec%0d_instr", i), if_instruction, tbl[i].v ? mem(tbl[i].pc) : NOP);
      chk($sformatf("vec%0d_trap", i), {31'h0, misaligned_trap}, {31'h0, tbl[i].trap});
      if (tbl[i].v) begin
        chk($sformatf("vec%0d_pc", i), if_pc, tbl[i].pc);
        chk($sformatf("vec%0d_pc4", i), if_pc_plus4, tbl[i].pc + 32'd4);
      end
      if (i == 0) begin
        chk("wrap_addr2", icache_address2, 32'h0);
        chk("wrap_pc2", if_pc2, 32'hFFFF_FFFC);
        chk("wrap_pc4_2", if_pc_plus42, 32'h0);
      end
    end

    // Two redirects during one miss: the later (misaligned) target wins.
    exp_a = icache_address;
    step(1'b0,1'b0,1'b0,32'h0 ,1'b1);
    step(1'b0,1'b0,1'b1,32'h64,1'b1);
    step(1'b0,1'b0,1'b1,32'h7A,1'b1);
    chk("redir_hold_addr", icache_address, exp_a);
    chk("redir_hold_valid", {31'h0, if_valid}, 32'h0);
    step(1'b0,1'b0,1'b0,32'h0 ,1'b0);
    chk("redir_addr", icache_address, TRAP_EN ? 32'h100 : 32'h78);
    chk("redir_trap", {31'h0, misaligned_trap}, {31'h0, TRAP_EN});
    chk("redir_valid", {31'h0, if_valid}, 32'h0);
    step(1'b0,1'b0,1'b0,32'h0 ,1'b0);
    chk("redir_trap_end", {31'h0, misaligned_trap}, 32'h0);
    chk("redir_next_pc", if_pc, TRAP_EN ? 32'h100 : 32'h78);
    chk("redir_next_valid", {31'h0, if_valid}, 32'h1);

    // Reset mid-miss with a parked redirect.
    stall = 1'b0; flush = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    icache_busywait = 1'b1;
    @(posedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_addr", icache_address, 32'h0);
    chk("mrst_valid", {31'h0, if_valid}, 32'h0);
    chk("mrst_instr", if_instruction, NOP);
    chk("mrst_addr2", icache_address2, 32'hFFFF_FFFC);
    chk("mrst_valid2", {31'h0, if_valid2}, 32'h0);
    @(negedge clock);
    branch_taken = 1'b0; icache_busywait = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1'b0,1'b0,1'b0,32'h0,1'b0);
    chk("mrst_first_addr", icache_address, 32'h4);
    chk("mrst_first_pc", if_pc, 32'h0);
    chk("mrst_first_valid", {31'h0, if_valid}, 32'h1);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(6) == 0,
           $urandom & 32'h0000_0FFF, $urandom_range(2) == 0);
      chk_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
INSTRUCTION_FETCH_STAGE -- requirements
Module: instruction_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, redirect target on misaligned branch (REQ-024).
REQ-003 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- stall  in  1  hazard-unit hold of PC and IF/ID.
- flush  in  1  kill the instruction being latched into IF/ID.
- branch_taken  in  1  one-cycle redirect request from EX.
- branch_target  in  32  redirect address.
- icache_busywait  in  1  icache miss in progress.
- icache_instruction  in  32  icache read data.
- icache_address  out  32  fetch address to icache.
- if_pc  out  32  IF/ID PC.
- if_pc_plus4  out  32  IF/ID PC+4.
- if_instruction  out  32  IF/ID instruction.
- if_valid  out  1  IF/ID holds a real instruction.
- misaligned_trap  out  1  one-cycle misaligned-target flag.

Function
REQ-004 icache_address SHALL equal the PC register combinationally.
REQ-005 FSM SHALL have states FETCH, MISS, MISS_REDIRECT.
REQ-006 PC+4 SHALL be modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-007 FETCH, busywait=0, stall=0, no branch: IF/ID SHALL latch {PC, PC+4, icache_instruction}, if_valid<=1, PC<=PC+4.
REQ-008 FETCH, busywait=1, no branch: PC SHALL hold, if_valid<=0 unless stall=1 (IF/ID holds), next state MISS.
REQ-009 MISS, busywait=1, no branch: PC SHALL hold, if_valid<=0 unless stall=1.
REQ-010 MISS, busywait=0: behave as REQ-007 that edge and return to FETCH (stall=1 holds everything, state FETCH).
REQ-011 stall=1 with busywait=0 and no branch: PC and all IF/ID registers SHALL hold.
REQ-012 branch_taken SHALL override stall.
REQ-013 FETCH, branch_taken=1, busywait=0: PC<=target, if_valid<=0, stay FETCH.
REQ-014 branch_taken while busywait=1 (FETCH or MISS): icache_address SHALL NOT change; target SHALL be saved in a pending register; next state MISS_REDIRECT.
REQ-015 MISS_REDIRECT, new branch_taken: pending target SHALL be overwritten (latest wins).
REQ-016 MISS_REDIRECT, busywait=0: returned instruction SHALL be discarded, PC<=pending target, if_valid<=0, next FETCH.
REQ-017 flush=1 SHALL force if_valid<=0 at that edge; PC follows REQ-007..016 unchanged.
REQ-018 Instructions with if_valid=0 SHALL present if_instruction=32'h0000_0013 (NOP).
REQ-019 Fetch latency: instruction at PC appears on IF/ID one edge after busywait=0 with PC on icache_address.

Reset
REQ-020 reset low SHALL asynchronously set PC=RESET_PC, state=FETCH, pending cleared, if_valid=0, if_pc=0, if_pc_plus4=0, if_instruction=32'h0000_0013, misaligned_trap=0.
REQ-021 Reset asserted mid-miss SHALL discard any pending redirect; after release fetch restarts at RESET_PC.
REQ-022 First fetch SHALL occur at the first rising edge after reset deasserts.

Configuration
REQ-023 Macro IFETCH_MISALIGN_TRAP_EN SHALL select misaligned-target handling.
REQ-024 Defined: target with bits[1:0]!=0 SHALL load TRAP_VECTOR instead (immediately or at miss end per REQ-013/016) and pulse misaligned_trap for exactly one cycle coincident with the PC load.
REQ-025 Undefined: target bits[1:0] SHALL be forced to 00, misaligned_trap tied 0.

Verification
REQ-026 Reset, busywait=0, instr=mem[pc]: PC 0->4->8; if_pc 0,4 with if_valid=1 on consecutive edges.
REQ-027 busywait=1 three cycles at PC 0x10: icache_address stays 0x10, if_valid=0 three cycles, then if_pc=0x10 valid.
REQ-028 branch_taken target 0x40 during miss at 0x20: address stays 0x20 until busywait=0; next PC 0x40, 0x20 instruction never valid.
REQ-029 stall=1 two cycles with branch_taken on second: PC jumps to target, if_valid=0.
REQ-030 Target 0x42, macro defined: PC=0x100, misaligned_trap one cycle; undefined: PC=0x40, trap 0.
REQ-031 RESET_PC=32'hFFFF_FFFC: next PC 0x0000_0000; reset pulse mid-miss -> PC=RESET_PC, if_valid=0.
